// File: rtl/imem_loader.sv
// Boot loader: byte stream -> big-endian 32-bit words written to instruction memory from address 0.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_res,
  output logic              done,
  output logic              error
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CSUM;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       count_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [23:0]       asm_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic        take;
  logic [15:0] n_rx;
  logic        n_too_big;
  logic        last_word;

  assign take      = rx_valid && rx_ready;
  assign n_rx      = {count_q[15:8], rx_data};
  assign n_too_big = 17'(n_rx) > 17'(MAX_WORDS);
  // Widened to 17 bits so N = MAX_WORDS compares without the index wrapping.
  assign last_word = 17'(word_idx_q) == (17'(count_q) - 17'd1);

  always_comb begin
    case (state_q)
      S_HDR_HI, S_HDR_LO, S_DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                     rx_ready = 1'b1;
`endif
      default:                    rx_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) state_q <= S_HDR_HI;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_HDR_HI: if (take) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (take) begin
          if (n_rx == 16'd0)  state_d = S_FINISH;
          else if (n_too_big) state_d = S_ERR;
          else                state_d = S_DATA;
        end
      end
      S_DATA: if (take && byte_cnt_q == 2'd3 && last_word) state_d = S_FINISH;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (take) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      count_q    <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      asm_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_res    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      done    <= (state_d == S_DONE);
      cpu_res <= (state_d == S_DONE);
      error   <= (state_d == S_ERR);
      if (take) begin
        case (state_q)
          S_HDR_HI: count_q[15:8] <= rx_data;
          S_HDR_LO: count_q[7:0]  <= rx_data;
          S_DATA: begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q + rx_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx_q;
              mem_wdata <= {asm_q, rx_data};
              if (!last_word) word_idx_q <= word_idx_q + 1'b1;
            end else begin
              asm_q <= {asm_q[15:0], rx_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
